// File: rtl/dot_prod_feeder_if.sv
// Handshake and data bundle between the CAF sample sequencer and its neighbours.
//   master : feeder side (accepts ref/rx samples and start, drives the x/y stream)
//   slave  : environment side (sample sources and the dot-product unit)
// Signals: ref load stream (tvalid/i/q/tready), rx load stream (tvalid/i/q/tready),
//          start, product tready, x/y beat stream, beat_last, lag, busy, done.
interface dot_prod_feeder_if #(
    parameter int unsigned xi_bits             = 12,
    parameter int unsigned xq_bits             = 12,
    parameter int unsigned yi_bits             = 12,
    parameter int unsigned yq_bits             = 12,
    parameter int unsigned buffer_counter_bits = 4
);
    logic                           s_axis_ref_tvalid;
    logic [xi_bits-1:0]             ref_i;
    logic [xq_bits-1:0]             ref_q;
    logic                           s_axis_ref_tready;
    logic                           s_axis_rx_tvalid;
    logic [yi_bits-1:0]             rx_i;
    logic [yq_bits-1:0]             rx_q;
    logic                           s_axis_rx_tready;
    logic                           start;
    logic                           m_axis_product_tready;
    logic                           m_axis_x_tvalid;
    logic [xi_bits-1:0]             xi;
    logic [xq_bits-1:0]             xq;
    logic                           m_axis_y_tvalid;
    logic [yi_bits-1:0]             yi;
    logic [yq_bits-1:0]             yq;
    logic                           beat_last;
    logic [buffer_counter_bits-1:0] lag;
    logic                           busy;
    logic                           done;

    modport master (
        input  s_axis_ref_tvalid, ref_i, ref_q, s_axis_rx_tvalid, rx_i, rx_q, start,
               m_axis_product_tready,
        output s_axis_ref_tready, s_axis_rx_tready, m_axis_x_tvalid, xi, xq,
               m_axis_y_tvalid, yi, yq, beat_last, lag, busy, done
    );

    modport slave (
        output s_axis_ref_tvalid, ref_i, ref_q, s_axis_rx_tvalid, rx_i, rx_q, start,
               m_axis_product_tready,
        input  s_axis_ref_tready, s_axis_rx_tready, m_axis_x_tvalid, xi, xq,
               m_axis_y_tvalid, yi, yq, beat_last, lag, busy, done
    );
endinterface

// File: rtl/dot_prod_feeder.sv
// Sample sequencer for the CAF correlation path. Buffers one reference vector and one
// received window, then on start streams x = ref[n], y = rx[n+lag] for every lag
// 0..buffer_length-dot_length, n 0..dot_length-1, into the dot-product unit.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dot_prod_feeder_if.master (load streams, start, x/y stream, status)
module dot_prod_feeder #(
    parameter int unsigned xi_bits                 = 12,
    parameter int unsigned xq_bits                 = 12,
    parameter int unsigned yi_bits                 = 12,
    parameter int unsigned yq_bits                 = 12,
    parameter int unsigned dot_length              = 5,
    parameter int unsigned dot_length_counter_bits = 3,
    parameter int unsigned buffer_length           = 8,
    parameter int unsigned buffer_counter_bits     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dot_prod_feeder_if.master bus
);
    localparam int unsigned RefAw = (dot_length > 1) ? $clog2(dot_length) : 1;
    localparam int unsigned RxAw  = (buffer_length > 1) ? $clog2(buffer_length) : 1;

    typedef logic [dot_length_counter_bits-1:0] n_t;
    typedef logic [buffer_counter_bits-1:0]     cnt_t;

    localparam n_t   NLast   = n_t'(dot_length - 1);
    localparam cnt_t LagLast = cnt_t'(buffer_length - dot_length);
    localparam cnt_t RefFull = cnt_t'(dot_length);
    localparam cnt_t RxFull  = cnt_t'(buffer_length);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_t;

    state_t state_q, state_d;
    cnt_t   ref_wptr_q, rx_wptr_q;
    n_t     n_q;
    cnt_t   lag_q;
    logic   gen_done_q;  // final beat already loaded into the output registers

    logic               x_valid_q;
    logic [xi_bits-1:0] xi_q;
    logic [xq_bits-1:0] xq_q;
    logic [yi_bits-1:0] yi_q;
    logic [yq_bits-1:0] yq_q;
    logic               last_q;
    cnt_t               lag_out_q;

    logic [xi_bits+xq_bits-1:0] ref_mem [dot_length];
    logic [yi_bits+yq_bits-1:0] rx_mem  [buffer_length];

    logic             ref_ready, rx_ready, ref_wr, rx_wr;
    logic             start_acc, stream_adv, load, final_acc, is_final;
    n_t               cur_n;
    cnt_t             cur_lag, rx_sum;
    logic [RefAw-1:0] ref_ra;
    logic [RxAw-1:0]  rx_ra;

    always_comb begin
        ref_ready  = (state_q == StIdle) && (ref_wptr_q < RefFull);
        rx_ready   = (state_q == StIdle) && (rx_wptr_q < RxFull);
        ref_wr     = bus.s_axis_ref_tvalid && ref_ready;
        rx_wr      = bus.s_axis_rx_tvalid && rx_ready;
        start_acc  = (state_q == StIdle) && bus.start &&
                     (ref_wptr_q == RefFull) && (rx_wptr_q == RxFull);
        stream_adv = (state_q == StStream) && !gen_done_q &&
                     (!x_valid_q || bus.m_axis_product_tready);
        // The first beat is loaded on the accepting edge itself, giving 1-cycle latency.
        load       = start_acc || stream_adv;
        final_acc  = (state_q == StStream) && gen_done_q && x_valid_q &&
                     bus.m_axis_product_tready;
        cur_n      = start_acc ? '0 : n_q;
        cur_lag    = start_acc ? '0 : lag_q;
        is_final   = (cur_n == NLast) && (cur_lag == LagLast);
        rx_sum     = cnt_t'(cur_n) + cur_lag;
        ref_ra     = RefAw'(cur_n);
        rx_ra      = RxAw'(rx_sum);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_acc) state_d = StStream;
            StStream: if (final_acc) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ref_wptr_q <= '0;
            rx_wptr_q  <= '0;
            n_q        <= '0;
            lag_q      <= '0;
            gen_done_q <= 1'b0;
            x_valid_q  <= 1'b0;
            xi_q       <= '0;
            xq_q       <= '0;
            yi_q       <= '0;
            yq_q       <= '0;
            last_q     <= 1'b0;
            lag_out_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDone) begin
                ref_wptr_q <= '0;
                rx_wptr_q  <= '0;
            end else begin
                if (ref_wr) ref_wptr_q <= ref_wptr_q + cnt_t'(1);
                if (rx_wr)  rx_wptr_q  <= rx_wptr_q + cnt_t'(1);
            end
            if (load) begin
                if (cur_n == NLast) begin
                    n_q   <= '0;
                    lag_q <= cur_lag + cnt_t'(1);
                end else begin
                    n_q   <= cur_n + n_t'(1);
                    lag_q <= cur_lag;
                end
                gen_done_q        <= is_final;
                x_valid_q         <= 1'b1;
                {xi_q, xq_q}      <= ref_mem[ref_ra];
                {yi_q, yq_q}      <= rx_mem[rx_ra];
                last_q            <= (cur_n == NLast);
                lag_out_q         <= cur_lag;
            end else if (bus.m_axis_product_tready) begin
                x_valid_q <= 1'b0;
            end
        end
    end

    // Sample storage needs no reset; a full reload always precedes use.
    always_ff @(posedge clk) begin
        if (ref_wr) ref_mem[RefAw'(ref_wptr_q)] <= {bus.ref_i, bus.ref_q};
        if (rx_wr)  rx_mem[RxAw'(rx_wptr_q)]    <= {bus.rx_i, bus.rx_q};
    end

    assign bus.s_axis_ref_tready = ref_ready;
    assign bus.s_axis_rx_tready  = rx_ready;
    assign bus.m_axis_x_tvalid   = x_valid_q;
    assign bus.m_axis_y_tvalid   = x_valid_q;
    assign bus.xi                = xi_q;
    assign bus.xq                = xq_q;
    assign bus.yi                = yi_q;
    assign bus.yq                = yq_q;
    assign bus.beat_last         = last_q;
    assign bus.lag               = lag_out_q;
    assign bus.busy              = (state_q == StStream);
    assign bus.done              = (state_q == StDone);
endmodule

// File: tb/tb_dot_prod_feeder.sv
module tb_dot_prod_feeder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dot_prod_feeder_if bus ();
    dot_prod_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    dot_prod_feeder_if bus8 ();
    dot_prod_feeder #(
        .dot_length(8), .dot_length_counter_bits(3), .buffer_length(8), .buffer_counter_bits(4)
    ) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct packed {
        logic [11:0] xi;
        logic [11:0] xq;
        logic [11:0] yi;
        logic [11:0] yq;
        logic        last;
        logic [3:0]  lag;
    } beat_t;

    typedef struct {
        int mode;      // 0: tready=1, 1: 1,0,0,1 pattern, 2: random
        int poke;      // drive load streams and start during the stream
        int ref_i0;
        int ref_q0;
        int rx_i0;
        int rx_q0;
        int rx_qstep;
    } scen_t;

    scen_t tab [4];
    scen_t cur;
    beat_t exp_q [$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int beats_acc = 0;
    int valid_seen = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_acc_cyc = -100;
    int rdy_mode = 0;
    int rcyc = 0;
    logic  stall_prev = 1'b0;
    beat_t held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic fail_now(input string name, input string what);
        total_cnt++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [11:0] g_ref_i(input int k); return 12'(cur.ref_i0 + k); endfunction
    function automatic logic [11:0] g_ref_q(input int k); return 12'(cur.ref_q0 + k); endfunction
    function automatic logic [11:0] g_rx_i(input int k);  return 12'(cur.rx_i0 + k);  endfunction
    function automatic logic [11:0] g_rx_q(input int k);
        return 12'(cur.rx_q0 + cur.rx_qstep * k);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        rcyc++;
        case (rdy_mode)
            1:       bus.m_axis_product_tready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
            2:       bus.m_axis_product_tready = 1'($urandom_range(0, 1));
            default: bus.m_axis_product_tready = 1'b1;
        endcase
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial forever begin
        beat_t cb;
        beat_t e;
        @(negedge clk);
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            cb = {bus.xi, bus.xq, bus.yi, bus.yq, bus.beat_last, bus.lag};
            if (stall_prev) check("stall_hold", {bus.m_axis_x_tvalid, cb}, {1'b1, held});
            if (bus.m_axis_x_tvalid) valid_seen++;
            if (bus.m_axis_x_tvalid && bus.m_axis_product_tready) begin
                if (exp_q.size() == 0) begin
                    fail_now("extra_beat", "beat accepted with empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {bus.m_axis_y_tvalid, cb}, {1'b1, e});
                    if (e.last && e.lag == 4'd3) last_acc_cyc = cyc;
                end
                beats_acc++;
            end
            stall_prev = bus.m_axis_x_tvalid && !bus.m_axis_product_tready;
            held = cb;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_expected();
        for (int lg = 0; lg < 4; lg++)
            for (int n = 0; n < 5; n++)
                exp_q.push_back({g_ref_i(n), g_ref_q(n), g_rx_i(n + lg), g_rx_q(n + lg),
                                 (n == 4), 4'(lg)});
    endtask

    // Load ref[k] for ref_lo<=k<ref_hi and rx[k] for rx_lo<=k<rx_hi; called at posedge+1.
    task automatic load(input int ref_lo, input int ref_hi, input int rx_lo, input int rx_hi);
        for (int k = 0; k < 8; k++) begin
            bus.s_axis_ref_tvalid = (k >= ref_lo) && (k < ref_hi);
            bus.s_axis_rx_tvalid  = (k >= rx_lo) && (k < rx_hi);
            bus.ref_i = g_ref_i(k);
            bus.ref_q = g_ref_q(k);
            bus.rx_i  = g_rx_i(k);
            bus.rx_q  = g_rx_q(k);
            if (bus.s_axis_ref_tvalid) check("ref_tready_load", bus.s_axis_ref_tready, 1);
            if (bus.s_axis_rx_tvalid)  check("rx_tready_load", bus.s_axis_rx_tready, 1);
            @(posedge clk);
            #1;
        end
        bus.s_axis_ref_tvalid = 1'b0;
        bus.s_axis_rx_tvalid  = 1'b0;
    endtask

    // Start a stream on loaded buffers and wait for done; called at posedge+1.
    task automatic run(input int poke);
        bit got = 0;
        done_cnt = 0;
        push_expected();
        bus.start = 1'b1;
        @(negedge clk);
        check("tvalid_pre_start", bus.m_axis_x_tvalid, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (poke != 0) begin
            bus.s_axis_ref_tvalid = 1'b1;
            bus.ref_i = 12'hABC;
            bus.ref_q = 12'h123;
            bus.s_axis_rx_tvalid = 1'b1;
            bus.rx_i = 12'h456;
            bus.rx_q = 12'h789;
            bus.start = 1'b1;
        end
        @(negedge clk);
        check("tvalid_latency", bus.m_axis_x_tvalid, 1);
        if (poke != 0)
            check("ready_low_stream",
                  {bus.busy, bus.s_axis_ref_tready, bus.s_axis_rx_tready}, 3'b100);
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) got = 1;
        end
        if (!got) fail_now("done_timeout", "no done within 400 cycles");
        bus.s_axis_ref_tvalid = 1'b0;
        bus.s_axis_rx_tvalid  = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("ready_idle", {bus.s_axis_ref_tready, bus.s_axis_rx_tready, bus.busy}, 3'b110);
        @(negedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("done_timing", done_cyc, last_acc_cyc + 1);
        check("sb_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int snap;
        bit got;
        tab[0] = '{0, 0, 1, 1, 10, 0, 0};
        tab[1] = '{1, 0, 1, 1, 10, 0, 0};
        tab[2] = '{2, 1, -7, 300, -100, 5, 3};
        tab[3] = '{0, 0, -7, 300, -100, 5, 3};
        cur = tab[0];

        rst_n = 1'b0;
        bus.s_axis_ref_tvalid = 0; bus.ref_i = 0; bus.ref_q = 0;
        bus.s_axis_rx_tvalid = 0;  bus.rx_i = 0;  bus.rx_q = 0;
        bus.start = 0;
        bus8.s_axis_ref_tvalid = 0; bus8.ref_i = 0; bus8.ref_q = 0;
        bus8.s_axis_rx_tvalid = 0;  bus8.rx_i = 0;  bus8.rx_q = 0;
        bus8.start = 0; bus8.m_axis_product_tready = 1;
        #23;
        check("rst_outputs", {bus.m_axis_x_tvalid, bus.m_axis_y_tvalid, bus.busy, bus.done,
                              bus.beat_last, bus.lag, bus.xi, bus.xq, bus.yi, bus.yq}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_treadys", {bus.s_axis_ref_tready, bus.s_axis_rx_tready}, 2'b11);

        // Table-driven full runs.
        for (int s = 0; s < 4; s++) begin
            cur = tab[s];
            rdy_mode = cur.mode;
            load(0, 5, 0, 8);
            run(cur.poke);
        end

        // Start with only four reference samples is ignored.
        cur = tab[0];
        rdy_mode = 0;
        load(0, 4, 0, 8);
        snap = valid_seen;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("partial_no_valid", valid_seen - snap, 0);
        check("partial_idle", {bus.busy, bus.s_axis_ref_tready}, 2'b01);
        load(4, 5, 0, 0);
        run(0);

        // Reset while beat 7 is presented.
        load(0, 5, 0, 8);
        push_expected();
        snap = beats_acc;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            #1;
            if (beats_acc - snap >= 6) got = 1;
        end
        if (!got) fail_now("reset_wait_timeout", "beat 7 never reached");
        rst_n = 1'b0;
        #1;
        check("mid_reset_out", {bus.m_axis_x_tvalid, bus.busy, bus.done}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("mid_reset_treadys", {bus.s_axis_ref_tready, bus.s_axis_rx_tready}, 2'b11);
        @(posedge clk);
        #1;
        load(0, 5, 0, 8);
        run(0);

        // Single-lag configuration: dot_length == buffer_length == 8.
        for (int k = 0; k < 8; k++) begin
            bus8.s_axis_ref_tvalid = 1; bus8.ref_i = 12'(20 + k); bus8.ref_q = 12'(30 + k);
            bus8.s_axis_rx_tvalid = 1;  bus8.rx_i = 12'(40 + k);  bus8.rx_q = 12'(50 + k);
            @(posedge clk);
            #1;
        end
        bus8.s_axis_ref_tvalid = 0;
        bus8.s_axis_rx_tvalid = 0;
        bus8.start = 1;
        @(posedge clk);
        #1;
        bus8.start = 0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            check("dl8_beat", {bus8.m_axis_x_tvalid, bus8.xi, bus8.xq, bus8.yi, bus8.yq,
                               bus8.beat_last, bus8.lag},
                  {1'b1, 12'(20 + b), 12'(30 + b), 12'(40 + b), 12'(50 + b), (b == 7), 4'd0});
        end
        @(negedge clk);
        check("dl8_done", {bus8.m_axis_x_tvalid, bus8.done}, 2'b01);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
